banked_mem: RTL and testbench

Parametrised multi-bank on-chip buffer for activation (x) and weight (w) storage: BANKS independent word-wide banks behind a single valid/ready request port, with registered reads and a hardware clear engine. It supersedes the fixed 1-bit, 4-bank, combinational-read, tri-stated memory system. Two instances (x-side, w-side) sit between the load controller and the MAC datapath.

---
 rtl/banked_mem_pkg.sv | 27 ++
 rtl/banked_mem_bank.sv | 34 +++
 rtl/banked_mem.sv | 171 +++++++++++++++++
 tb/tb_banked_mem.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/banked_mem_pkg.sv
// banked_mem_pkg: shared constants and helpers for the banked activation /
// weight buffer (FSM state encodings, bank-select width, parity helper).
package banked_mem_pkg;

  // Controller states: CLEAR sweeps every address to zero, IDLE serves requests.
  typedef logic [0:0] state_t;
  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_IDLE  = 1'b1;

  // Widest data word the parity helper accepts.
  localparam int PAR_MAX_W = 64;

  // Bank-select width: at least one bit, even for a single bank.
  function automatic int sel_width(input int banks);
    if (banks > 1) begin
      return $clog2(banks);
    end else begin
      return 1;
    end
  endfunction

  // Even-parity bit of a word; zero-extension leaves the XOR unchanged.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/banked_mem_bank.sv
// banked_mem_bank: one DEPTH x MEM_W single-port storage array with a
// synchronous write and a registered read. The read register only updates on
// an enabled read, so an idle or written bank keeps presenting its last read.
module banked_mem_bank #(
  parameter int MEM_W  = 1,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [MEM_W-1:0]  wdata,
  output logic [MEM_W-1:0]  rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [MEM_W-1:0] mem_r [DEPTH];
  logic [MEM_W-1:0] rd_r;

  // Single port: an enabled cycle either writes the array or loads the read register.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[addr] <= wdata;
      end else begin
        rd_r <= mem_r[addr];
      end
    end
  end

  assign rdata = rd_r;

endmodule

// File: rtl/banked_mem.sv
// banked_mem: BANKS independent word-wide banks behind one valid/ready request
// port, one-cycle registered reads and a hardware clear sweep that runs after
// reset and on clr_start.
// Optional feature macro: BANKED_MEM_PARITY_EN adds one stored even-parity bit
// per word and reports mismatches on rsp_perr (tied 0 when undefined).
module banked_mem
  import banked_mem_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int ADDR_W = 10,
  parameter int BANKS  = 4,
  localparam int SEL_W = sel_width(BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [SEL_W-1:0]  req_bank,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              clr_start,
  output logic              busy,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_perr
);

`ifdef BANKED_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [SEL_W:0]    BANKS_V   = (SEL_W + 1)'(BANKS);

  state_t            state_r;
  logic [ADDR_W-1:0] clr_addr_r;
  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic              rsp_zero_r;
  logic [SEL_W-1:0]  rd_sel_r;

  logic              clearing_s;
  logic              accept_s;
  logic              bank_ok_s;
  logic              rd_acc_s;
  logic [ADDR_W-1:0] bank_addr_s;
  logic [MEM_W-1:0]  req_word_s;
  logic [MEM_W-1:0]  bank_wdata_s;
  logic [BANKS-1:0]  bank_en_s;
  logic              bank_we_s;
  logic [MEM_W-1:0]  bank_rdata_s [BANKS];
  logic [MEM_W-1:0]  sel_word_s;

  assign clearing_s = (state_r == ST_CLEAR);
  assign req_ready  = (state_r == ST_IDLE);
  assign busy       = clearing_s;

  // clr_start wins over a request presented in the same IDLE cycle.
  assign accept_s  = req_valid & req_ready & ~clr_start;
  assign bank_ok_s = ({1'b0, req_bank} < BANKS_V);
  assign rd_acc_s  = accept_s & ~req_we;

`ifdef BANKED_MEM_PARITY_EN
  assign req_word_s = {even_parity(PAR_MAX_W'(req_wdata)), req_wdata};
`else
  assign req_word_s = req_wdata;
`endif

  // Shared bank port: the sweep drives zeros to every bank, otherwise the request does.
  always_comb begin
    bank_addr_s  = req_addr;
    bank_wdata_s = req_word_s;
    bank_we_s    = req_we;
    if (clearing_s) begin
      bank_addr_s  = clr_addr_r;
      bank_wdata_s = '0;
      bank_we_s    = 1'b1;
    end else begin
      bank_addr_s  = req_addr;
      bank_wdata_s = req_word_s;
      bank_we_s    = req_we;
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    // Only the addressed bank is enabled; the sweep enables them all at once.
    assign bank_en_s[b] = clearing_s | (accept_s & (req_bank == SEL_W'(b)));

    banked_mem_bank #(
      .MEM_W  (MEM_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk   (clk),
      .en    (bank_en_s[b]),
      .we    (bank_we_s),
      .addr  (bank_addr_s),
      .wdata (bank_wdata_s),
      .rdata (bank_rdata_s[b])
    );
  end

  // Clear sweep and IDLE/CLEAR sequencing; reset restarts the sweep from address 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_CLEAR;
      clr_addr_r <= '0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (clr_addr_r == ADDR_LAST) begin
            state_r    <= ST_IDLE;
            clr_addr_r <= '0;
          end else begin
            clr_addr_r <= clr_addr_r + ADDR_W'(1'b1);
          end
        end
        ST_IDLE: begin
          if (clr_start) begin
            state_r    <= ST_CLEAR;
            clr_addr_r <= '0;
          end
        end
        default: begin
          state_r    <= ST_CLEAR;
          clr_addr_r <= '0;
        end
      endcase
    end
  end

  // Response tracking: which bank feeds rsp_data, and whether it must read as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_zero_r  <= 1'b1;
      rd_sel_r    <= '0;
    end else begin
      rsp_valid_r <= rd_acc_s;
      rsp_err_r   <= rd_acc_s & ~bank_ok_s;
      if (rd_acc_s) begin
        rsp_zero_r <= ~bank_ok_s;
        rd_sel_r   <= req_bank;
      end
    end
  end

  // Select the read register of the last-read bank (one-hot OR, no out-of-range index).
  always_comb begin
    sel_word_s = '0;
    for (int b = 0; b < BANKS; b++) begin
      sel_word_s = sel_word_s | ((rd_sel_r == SEL_W'(b)) ? bank_rdata_s[b] : '0);
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_data  = rsp_zero_r ? '0 : sel_word_s[DATA_W-1:0];

`ifdef BANKED_MEM_PARITY_EN
  assign rsp_perr = rsp_valid_r & ~rsp_zero_r &
                    (even_parity(PAR_MAX_W'(sel_word_s[DATA_W-1:0])) != sel_word_s[DATA_W]);
`else
  assign rsp_perr = 1'b0;
`endif

endmodule

// File: tb/tb_banked_mem.sv
// tb_banked_mem: directed bench driving one shared request stream into a
// 4-bank instance and a 3-bank instance (bank 3 out of range on the latter).
module tb_banked_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_we;
  logic [1:0] req_bank;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       clr_start;

  logic       ready4, busy4, rv4, re4, rp4;
  logic [7:0] rd4;
  logic       ready3, busy3, rv3, re3, rp3;
  logic [7:0] rd3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  banked_mem #(.DATA_W(8), .ADDR_W(4), .BANKS(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready4),
    .req_we(req_we), .req_bank(req_bank), .req_addr(req_addr),
    .req_wdata(req_wdata), .clr_start(clr_start), .busy(busy4),
    .rsp_valid(rv4), .rsp_data(rd4), .rsp_err(re4), .rsp_perr(rp4)
  );

  banked_mem #(.DATA_W(8), .ADDR_W(4), .BANKS(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready3),
    .req_we(req_we), .req_bank(req_bank), .req_addr(req_addr),
    .req_wdata(req_wdata), .clr_start(clr_start), .busy(busy3),
    .rsp_valid(rv3), .rsp_data(rd3), .rsp_err(re3), .rsp_perr(rp3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] b, input logic [3:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_bank = b; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] b, input logic [3:0] a);
    req_valid = 1'b1; req_we = 1'b0; req_bank = b; req_addr = a;
    step();
    req_valid = 1'b0;
  endtask

  // Count busy cycles (bounded) and confirm ready stayed low throughout.
  task automatic wait_clear(input string tag);
    int   n = 0;
    logic saw_ready = 1'b0;
    while (busy4 && n < 200) begin
      if (ready4) saw_ready = 1'b1;
      step();
      n++;
    end
    check_eq({tag, "_len"}, 32'(n), 32'd16);
    check_eq({tag, "_rdy_in_clr"}, 32'(saw_ready), 32'd0);
    check_eq({tag, "_ready_after"}, 32'(ready4), 32'd1);
    check_eq({tag, "_busy3_after"}, 32'(busy3), 32'd0);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_bank = 2'd0;
    req_addr = 4'd0; req_wdata = 8'd0; clr_start = 1'b0;
    step();
    step();
    check_eq("rst_ready", 32'(ready4), 32'd0);
    check_eq("rst_busy", 32'(busy4), 32'd1);
    check_eq("rst_rv", 32'(rv4), 32'd0);
    check_eq("rst_data", 32'(rd4), 32'd0);
    check_eq("rst_err", 32'(re4), 32'd0);
    check_eq("rst_perr", 32'(rp4), 32'd0);
    rst = 1'b1;
    wait_clear("init");

    // Cleared word reads as zero one cycle after acceptance.
    do_read(2'd2, 4'd5);
    check_eq("rd0_valid", 32'(rv4), 32'd1);
    check_eq("rd0_data", 32'(rd4), 32'h00);
    check_eq("rd0_err", 32'(re4), 32'd0);
    step();
    check_eq("rd0_pulse", 32'(rv4), 32'd0);

    // Back-to-back writes then back-to-back reads.
    req_valid = 1'b1; req_we = 1'b1; req_bank = 2'd1; req_addr = 4'd3; req_wdata = 8'hA5;
    step();
    req_bank = 2'd2; req_wdata = 8'h5A;
    step();
    check_eq("wr_no_rsp", 32'(rv4), 32'd0);
    req_we = 1'b0; req_bank = 2'd1;
    step();
    check_eq("b2b_v1", 32'(rv4), 32'd1);
    check_eq("b2b_d1", 32'(rd4), 32'hA5);
    req_bank = 2'd2;
    step();
    req_valid = 1'b0;
    check_eq("b2b_v2", 32'(rv4), 32'd1);
    check_eq("b2b_d2", 32'(rd4), 32'h5A);
    check_eq("b2b_d2_b3", 32'(rd3), 32'h5A);
    step();
    check_eq("hold_v", 32'(rv4), 32'd0);
    check_eq("hold_d", 32'(rd4), 32'h5A);
    do_read(2'd0, 4'd3);
    check_eq("b0a3_zero", 32'(rd4), 32'h00);
    do_read(2'd3, 4'd3);
    check_eq("b3a3_zero", 32'(rd4), 32'h00);
    check_eq("b3a3_err4", 32'(re4), 32'd0);

    // Write then read on the very next cycle.
    do_write(2'd0, 4'd15, 8'hFF);
    do_read(2'd0, 4'd15);
    check_eq("wr_rd_v", 32'(rv4), 32'd1);
    check_eq("wr_rd_d", 32'(rd4), 32'hFF);

    // clr_start beats a same-cycle read; writes held during the sweep are refused.
    clr_start = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_bank = 2'd0; req_addr = 4'd15;
    step();
    clr_start = 1'b0;
    check_eq("clr_rd_dropped", 32'(rv4), 32'd0);
    check_eq("clr_busy", 32'(busy4), 32'd1);
    req_we = 1'b1; req_wdata = 8'h22;
    wait_clear("clr");
    req_valid = 1'b0; req_we = 1'b0;
    do_read(2'd0, 4'd15);
    check_eq("clr_reread", 32'(rd4), 32'h00);
    do_read(2'd1, 4'd3);
    check_eq("clr_b1a3", 32'(rd4), 32'h00);

    // Reset at clr_addr=7 restarts the full sweep.
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (7) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    wait_clear("rst_sweep");

    // Reset in the accept cycle of a read drops the response.
    do_write(2'd1, 4'd2, 8'h3C);
    rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_bank = 2'd1; req_addr = 4'd2;
    step();
    rst = 1'b1; req_valid = 1'b0;
    check_eq("rst_rd_rv", 32'(rv4), 32'd0);
    check_eq("rst_rd_data", 32'(rd4), 32'd0);
    wait_clear("rst_rd");

    // Out-of-range bank on the 3-bank instance.
    do_write(2'd0, 4'd4, 8'h10);
    do_write(2'd1, 4'd4, 8'h20);
    do_write(2'd2, 4'd4, 8'h30);
    do_write(2'd3, 4'd4, 8'h77);
    do_read(2'd0, 4'd4);
    check_eq("oor_b0", 32'(rd3), 32'h10);
    do_read(2'd1, 4'd4);
    check_eq("oor_b1", 32'(rd3), 32'h20);
    do_read(2'd2, 4'd4);
    check_eq("oor_b2", 32'(rd3), 32'h30);
    check_eq("oor_b2_err", 32'(re3), 32'd0);
    do_read(2'd3, 4'd4);
    check_eq("oor_rv", 32'(rv3), 32'd1);
    check_eq("oor_err", 32'(re3), 32'd1);
    check_eq("oor_data", 32'(rd3), 32'h00);
    check_eq("oor_perr", 32'(rp3), 32'd0);
    check_eq("b3_valid4_data", 32'(rd4), 32'h77);
    check_eq("b3_valid4_err", 32'(re4), 32'd0);
    step();
    check_eq("oor_err_pulse", 32'(re3), 32'd0);
    check_eq("oor_hold_zero", 32'(rd3), 32'h00);

`ifdef BANKED_MEM_PARITY_EN
    do_write(2'd0, 4'd6, 8'h01);
    u_dut4.g_bank[0].u_bank.mem_r[6][0] = ~u_dut4.g_bank[0].u_bank.mem_r[6][0];
    do_read(2'd0, 4'd6);
    check_eq("par_flip", 32'(rp4), 32'd1);
    do_read(2'd1, 4'd4);
    check_eq("par_clean", 32'(rp4), 32'd0);
`else
    do_read(2'd1, 4'd4);
    check_eq("perr_tied", 32'(rp4), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
